fpmul_iter: RTL and testbench

Parametrised, multicycle IEEE-754-style floating-point multiplier with a valid/ready handshake on both sides, selectable rounding mode and sticky exception flags per result. It replaces the single-cycle combinational multiplier in the FP datapath. It computes the significand product with a radix-2 shift-add loop, so one small adder is shared across cycles. It sits between the FP register-read stage and the FP writeback mux of the multicycle core.

---
 rtl/fpmul_iter_if.sv | 27 ++
 rtl/fpmul_iter.sv | 228 ++++++++++++++++++++++
 tb/tb_fpmul_iter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fpmul_iter_if.sv
// Handshake and operand/result bundle for the iterative FP multiplier.
interface fpmul_iter_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = EXP_W + MAN_W + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         rm;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, rm, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, rm, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fpmul_iter.sv
// Multicycle FP multiplier: radix-2 shift-add significand product,
// DAZ/FTZ, RNE or RTZ rounding, flags {invalid, overflow, underflow, inexact}.
module fpmul_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         reset,
  fpmul_iter_if.slave  io
);
  localparam int W      = EXP_W + MAN_W + 1;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int E_W    = EXP_W + 2;
  localparam int CNT_W  = $clog2(SIG_W);
  localparam int BIAS   = 2 ** (EXP_W - 1) - 1;
  localparam int EMAX   = 2 ** EXP_W - 1;

  localparam logic signed [E_W-1:0] E_BIAS = E_W'(BIAS);
  localparam logic signed [E_W-1:0] E_MAX  = E_W'(EMAX);
  localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
  localparam logic signed [E_W-1:0] E_ZERO = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PROD_W-1:0]       acc_q, acc_d;
  logic [SIG_W-1:0]        mcand_q, mcand_d;
  logic [SIG_W-1:0]        mplier_q, mplier_d;
  logic signed [E_W-1:0]   e_q, e_d;
  logic                    sign_q, sign_d;
  logic                    rm_q, rm_d;
  logic [W-1:0]            result_q, result_d;
  logic [3:0]              flags_q, flags_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;

  // operand fields and classes
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             sign_ab;
  logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic             special;
  logic [W-1:0]     spec_res;
  logic             spec_inv;
  logic signed [E_W-1:0] e_sum;

  assign ea      = io.a[W-2 -: EXP_W];
  assign eb      = io.b[W-2 -: EXP_W];
  assign fa      = io.a[MAN_W-1:0];
  assign fb      = io.b[MAN_W-1:0];
  assign sign_ab = io.a[W-1] ^ io.b[W-1];

  // Exponent fields of zero cover both true zero and subnormals (DAZ).
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_snan = a_nan & ~fa[MAN_W-1];
  assign b_snan = b_nan & ~fb[MAN_W-1];
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_zero = ~(|ea);
  assign b_zero = ~(|eb);
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
  assign e_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - E_BIAS;

  // Special-case result, priority NaN > 0*inf > inf > zero.
  always_comb begin
    spec_res = {sign_ab, {(W-1){1'b0}}};
    spec_inv = 1'b0;
    if (a_nan | b_nan) begin
      spec_res = QNAN;
      spec_inv = a_snan | b_snan;
    end else if ((a_inf & b_zero) | (a_zero & b_inf)) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (a_inf | b_inf) begin
      spec_res = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // One shift-add step: add multiplicand into the upper half, shift right.
  logic [SIG_W:0]    mul_sum;
  logic [PROD_W-1:0] mul_acc;
  always_comb begin
    mul_sum = {1'b0, acc_q[PROD_W-1:SIG_W]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    mul_acc = {mul_sum, acc_q[SIG_W-1:1]};
  end

  // Rounding and range check on the normalised product (MSB at PROD_W-1).
  logic [MAN_W-1:0]      frac_t, frac_f;
  logic [MAN_W:0]        frac_r;
  logic                  g_bit, r_bit, s_bit, rnd_inc, inexact;
  logic signed [E_W-1:0] e_r;
  logic [W-1:0]          rnd_res;
  logic [3:0]            rnd_flags;
  always_comb begin
    frac_t  = acc_q[PROD_W-2 -: MAN_W];
    g_bit   = acc_q[PROD_W-2-MAN_W];
    r_bit   = acc_q[PROD_W-3-MAN_W];
    s_bit   = |acc_q[PROD_W-4-MAN_W:0];
    inexact = g_bit | r_bit | s_bit;
    rnd_inc = ~rm_q & g_bit & (r_bit | s_bit | frac_t[0]);
    frac_r  = {1'b0, frac_t} + {{MAN_W{1'b0}}, rnd_inc};
    e_r     = frac_r[MAN_W] ? e_q + E_ONE : e_q;
    frac_f  = frac_r[MAN_W] ? '0 : frac_r[MAN_W-1:0];
    if (e_r >= E_MAX) begin
      rnd_res   = rm_q ? {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                       : {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flags = 4'b0101;
    end else if (e_r <= E_ZERO) begin
      rnd_res   = {sign_q, {(W-1){1'b0}}};
      rnd_flags = 4'b0011;
    end else begin
      rnd_res   = {sign_q, e_r[EXP_W-1:0], frac_f};
      rnd_flags = {3'b000, inexact};
    end
  end

  // Next-state and next-register values for the control FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    e_d         = e_q;
    sign_d      = sign_q;
    rm_d        = rm_q;
    result_d    = result_q;
    flags_d     = flags_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          sign_d     = sign_ab;
          rm_d       = io.rm;
          in_ready_d = 1'b0;
          if (special) begin
            state_d     = DONE;
            result_d    = spec_res;
            flags_d     = {spec_inv, 3'b000};
            out_valid_d = 1'b1;
          end else begin
            state_d  = MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {1'b1, fa};
            mplier_d = {1'b1, fb};
            e_d      = e_sum;
          end
        end
      end
      MUL: begin
        acc_d    = mul_acc;
        mplier_d = {1'b0, mplier_q[SIG_W-1:1]};
        if (cnt_q == CNT_W'(MAN_W)) begin
          cnt_d   = '0;
          state_d = NORM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      NORM: begin
        // Product of two [1,2) significands lies in [1,4): at most one shift.
        if (acc_q[PROD_W-1]) e_d = e_q + E_ONE;
        else                 acc_d = {acc_q[PROD_W-2:0], 1'b0};
        state_d = ROUND;
      end
      ROUND: begin
        result_d    = rnd_res;
        flags_d     = rnd_flags;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      e_q         <= '0;
      sign_q      <= 1'b0;
      rm_q        <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      e_q         <= e_d;
      sign_q      <= sign_d;
      rm_q        <= rm_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.flags     = flags_q;
endmodule

// File: tb/tb_fpmul_iter.sv
// Bench for fpmul_iter: directed vectors, arithmetic reference model,
// per-cycle compare of handshake, latency and result.
module tb_fpmul_iter;
  localparam int MAN_W = 23;
  localparam int NV    = 17;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fpmul_iter_if io();
  fpmul_iter dut (.clk(clk), .reset(reset), .io(io));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { logic [31:0] res; logic [3:0] flg; bit spec; } exp_t;
  typedef struct { logic [31:0] res; logic [3:0] flg; int due; } pend_t;
  pend_t pq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact integer product, remainder-vs-half rounding.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic rm);
    exp_t   r;
    logic   s;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    bit     an, bn, asn, bsn, ai, bi, az, bz, inx;
    longint p, q, rem, half;
    int     e, sh;
    s = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
    an = (ea == 8'hFF) && (fa != 0); bn = (eb == 8'hFF) && (fb != 0);
    asn = an && !fa[22]; bsn = bn && !fb[22];
    ai = (ea == 8'hFF) && (fa == 0); bi = (eb == 8'hFF) && (fb == 0);
    az = (ea == 0); bz = (eb == 0);
    r.spec = an || bn || ai || bi || az || bz;
    r.flg = 4'b0000;
    if (an || bn) begin
      r.res = 32'h7FC00000; r.flg[3] = asn || bsn;
    end else if ((ai && bz) || (az && bi)) begin
      r.res = 32'h7FC00000; r.flg[3] = 1'b1;
    end else if (ai || bi) begin
      r.res = {s, 8'hFF, 23'h0};
    end else if (az || bz) begin
      r.res = {s, 31'h0};
    end else begin
      p = longint'({1'b1, fa}) * longint'({1'b1, fb});
      e = int'(ea) + int'(eb) - 127;
      if (p >= (64'd1 << 47)) begin sh = 24; e++; end
      else sh = 23;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      inx  = (rem != 0);
      if (!rm && (rem > half || (rem == half && q[0]))) q++;
      if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
      if (e >= 255) begin
        r.res = rm ? {s, 8'hFE, 23'h7FFFFF} : {s, 8'hFF, 23'h0};
        r.flg = 4'b0101;
      end else if (e <= 0) begin
        r.res = {s, 31'h0};
        r.flg = 4'b0011;
      end else begin
        r.res = {s, 8'(e), q[22:0]};
        r.flg = {3'b000, inx};
      end
    end
    return r;
  endfunction

  // Cycle-by-cycle compare against the model's outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset) begin
      chk("rst_in_ready", 32'(io.in_ready), 1);
      chk("rst_out_valid", 32'(io.out_valid), 0);
      chk("rst_result", io.result, 0);
      chk("rst_flags", 32'(io.flags), 0);
      pq.delete();
    end else if (pq.size() == 0) begin
      chk("idle_in_ready", 32'(io.in_ready), 1);
      chk("idle_out_valid", 32'(io.out_valid), 0);
      if (io.in_valid) begin
        e = model(io.a, io.b, io.rm);
        pq.push_back('{res: e.res, flg: e.flg, due: cyc + (e.spec ? 1 : MAN_W + 4)});
      end
    end else begin
      chk("busy_in_ready", 32'(io.in_ready), 0);
      chk("out_valid_timing", 32'(io.out_valid), 32'(cyc >= pq[0].due));
      if (cyc >= pq[0].due) begin
        chk("result", io.result, pq[0].res);
        chk("flags", 32'(io.flags), 32'(pq[0].flg));
        if (io.out_ready) void'(pq.pop_front());
      end
    end
  end

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic rm,
                     input logic [31:0] er, input logic [3:0] ef, input int hold);
    exp_t m;
    int   n;
    m = model(a, b, rm);
    chk("model_res", m.res, er);
    chk("model_flags", 32'(m.flg), 32'(ef));
    @(posedge clk); #1;
    io.a = a; io.b = b; io.rm = rm; io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    io.a = $urandom; io.b = $urandom; io.rm = ~rm;
    n = 0;
    while (!io.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!io.out_valid) begin
      total++; bad++;
      $display("FAIL timeout: no out_valid for %h x %h", a, b);
    end else begin
      chk("lit_res", io.result, er);
      chk("lit_flags", 32'(io.flags), 32'(ef));
      if (hold > 0) begin
        io.in_valid = 1'b1;
        repeat (hold) begin
          io.a = $urandom; io.b = $urandom;
          @(posedge clk); #1;
        end
        io.in_valid = 1'b0;
        chk("hold_res", io.result, er);
      end
      io.out_ready = 1'b1;
      @(posedge clk); #1;
      io.out_ready = 1'b0;
    end
  endtask

  logic [31:0] va [NV] = '{32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h3FFFFFFF, 32'h3FFFFFFF,
                           32'h3FC00000, 32'h3FC00000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000000,
                           32'h7FA00000, 32'h80000000, 32'h00800000, 32'h00000001, 32'hBFC00000,
                           32'h7F800000, 32'h7FC00000};
  logic [31:0] vb [NV] = '{32'h40000000, 32'h3F800001, 32'h3F800001, 32'h3FFFFFFF, 32'h3FFFFFFF,
                           32'h3F800001, 32'h3F800001, 32'h40000000, 32'h40000000, 32'hFF800000,
                           32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h3F800000, 32'h40000000,
                           32'hC0000000, 32'h00000000};
  logic        vr [NV] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  logic [31:0] ve [NV] = '{32'h40400000, 32'h3F800002, 32'h3F800002, 32'h407FFFFE, 32'h407FFFFE,
                           32'h3FC00002, 32'h3FC00001, 32'h7F800000, 32'h7F7FFFFF, 32'h7FC00000,
                           32'h7FC00000, 32'h80000000, 32'h00000000, 32'h00000000, 32'hC0400000,
                           32'hFF800000, 32'h7FC00000};
  logic [3:0]  vf [NV] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h5, 4'h5, 4'h8,
                           4'h8, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};

  initial begin
    io.in_valid = 1'b0; io.a = '0; io.b = '0; io.rm = 1'b0; io.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < NV; i++) run(va[i], vb[i], vr[i], ve[i], vf[i], 0);
    // consumer stalls for 10 cycles while new operands are offered
    run(32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'h0, 10);
    // abort mid-multiply
    @(posedge clk); #1;
    io.a = 32'h3FC00000; io.b = 32'h40000000; io.rm = 1'b0; io.in_valid = 1'b1;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (30) @(posedge clk);
    #1 chk("abort_no_valid", 32'(io.out_valid), 0);
    run(32'h40000000, 32'h40400000, 1'b0, 32'h40C00000, 4'h0, 0);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
